ldpc_parity_readout: RTL and testbench

LDPC_PARITY_READOUT -- requirements
Module: ldpc_parity_readout

---
 rtl/ldpc_parity_readout_if.sv | 25 ++
 rtl/ldpc_parity_readout.sv | 186 ++++++++++++++++++
 tb/tb_ldpc_parity_readout.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_parity_readout_if.sv
// Bundles the parity-RAM read port and the serial parity output stream of
// ldpc_parity_readout. The master side is the readout engine; the slave side is
// the RAM plus the downstream consumer.
interface ldpc_parity_readout_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 360
);
  logic                  re;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  m_valid;
  logic                  m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output re, rd_addr, m_valid, m_data, m_last,
    input  rd_data, m_ready
  );

  modport slave (
    input  re, rd_addr, m_valid, m_data, m_last,
    output rd_data, m_ready
  );
endinterface

// File: rtl/ldpc_parity_readout.sv
// Parity readout engine for an LDPC encoder. Walks the parity RAM column by
// column (rows inner loop), picks bit c of each row and streams the running
// XOR of those bits as a 1-bit valid/ready stream. A two-entry skid buffer
// absorbs the one-cycle RAM latency so the stream sustains one beat per cycle
// and never drops or repeats a bit under back-pressure.
module ldpc_parity_readout #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 360,
  parameter int DEPTH      = 72
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] q_rows,
  output logic                  busy,
  output logic                  done,
  ldpc_parity_readout_if.master bus
);

  localparam int                    COL_WIDTH   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [COL_WIDTH-1:0]  COL_LAST    = COL_WIDTH'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Control state
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] q_q, q_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  done_q, done_d;

  // Read in flight: the bit column it targets and whether it is the frame's last bit
  logic                  pend_q;
  logic [COL_WIDTH-1:0]  pend_col_q;
  logic                  pend_last_q;

  // Skid buffer holding raw bits; the accumulator is applied at the output
  logic [1:0]            buf_raw_q;
  logic [1:0]            buf_last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  acc_q;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  row_wrap;
  logic                  last_rd;
  logic                  q_ok;
  logic [1:0]            occ_after;

  // Output stream is driven straight from registers so it cannot change during a stall
  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = bus.m_valid & (acc_q ^ buf_raw_q[rd_ptr_q]);
  assign bus.m_last  = bus.m_valid & buf_last_q[rd_ptr_q];

  assign pop       = bus.m_valid & bus.m_ready;
  assign push      = pend_q;
  // Occupancy the buffer will have once this cycle's pop and returning read settle
  assign occ_after = count_q + {1'b0, pend_q} - {1'b0, pop};
  assign issue     = (state_q == S_RUN) && (occ_after < 2'd2);
  assign row_wrap  = (row_q == q_q - ADDR_WIDTH'(1));
  assign last_rd   = row_wrap && (col_q == COL_LAST);
  assign q_ok      = (q_rows != '0) && ({1'b0, q_rows} <= DEPTH_LIMIT);

  assign bus.re      = issue;
  assign bus.rd_addr = row_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

  // Next-state logic: frame acceptance, row/column sweep and drain completion
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_d = state_q;
    q_d     = q_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (q_ok) begin
            q_d     = q_rows;
            row_d   = '0;
            col_d   = '0;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          if (row_wrap) begin
            row_d = '0;
            if (col_q == COL_LAST) begin
              state_d = S_DRAIN;
            end else begin
              col_d = col_q + COL_WIDTH'(1);
            end
          end else begin
            row_d = row_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pop && bus.m_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  // Track the read issued this cycle so its data can be captured next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_col_q  <= '0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= issue;
      pend_col_q  <= col_q;
      pend_last_q <= issue && last_rd;
    end
  end

  // Two-entry skid buffer: capture returning bits, release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two storage entries are only a few flops, so they are reset along with the pointers; a real RAM array would not be.
    if (!rst_n) begin
      buf_raw_q  <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push) begin
        buf_raw_q[wr_ptr_q]  <= bus.rd_data[pend_col_q];
        buf_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Parity accumulator: latches each accepted output bit, cleared between frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      acc_q <= 1'b0;
    end else if (pop) begin
      acc_q <= bus.m_data;
    end
  end

endmodule

// File: tb/tb_ldpc_parity_readout.sv
// Self-checking bench for ldpc_parity_readout: a RAM model with one-cycle read
// latency, a reference model that builds each frame's expected bit stream from
// the RAM contents, and a negedge monitor that scoreboards every beat and
// tracks busy/done/latency/stall behaviour.
module tb_ldpc_parity_readout;
  localparam int AW    = 7;
  localparam int DW    = 360;
  localparam int DEPTH = 72;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] q_rows = '0;
  logic          busy;
  logic          done;

  ldpc_parity_readout_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ldpc_parity_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .q_rows (q_rows),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [DEPTH];

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // Data valid one cycle after re; junk otherwise so stale reads are visible
  always @(posedge clk) bus.rd_data <= bus.re ? ram[bus.rd_addr] : rand_row();

  // ---------------- reference model ----------------
  logic [1:0] exp_q [$];   // {expected m_data, expected m_last}
  int         exp_n = 0;

  task automatic push_expected(input int q);
    logic acc = 1'b0;
    exp_n = DW * q;
    for (int m = 0; m < exp_n; m++) begin
      int c = m / q;
      int r = m % q;
      acc = acc ^ ram[r][c];
      exp_q.push_back({acc, (m == exp_n - 1)});
    end
  endtask

  // ---------------- downstream ready ----------------
  bit ready_random = 1'b0;
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.m_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit         busy_model = 1'b0;
  bit         done_model = 1'b0;
  bit         done_next;
  bit         first_seen = 1'b0;
  int         since_start = 0;
  int         beat_cnt = 0;
  int         bubbles = 0;
  int         done_cnt = 0;
  bit         prev_valid = 1'b0;
  bit         prev_ready = 1'b0;
  logic       prev_data = 1'b0;
  logic       prev_last = 1'b0;
  logic [1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("outputs_in_reset",
            {bus.re, bus.rd_addr, bus.m_valid, bus.m_data, bus.m_last, busy, done}, '0);
      exp_q.delete();
      busy_model = 1'b0;
      done_model = 1'b0;
      first_seen = 1'b0;
      beat_cnt   = 0;
      prev_valid = 1'b0;
    end else begin
      done_next = 1'b0;
      check("busy", busy, busy_model);
      if (done || done_model) check("done_pulse", done, done_model);
      if (done) done_cnt++;
      if (!busy_model) check("valid_while_idle", bus.m_valid, 1'b0);
      if (prev_valid && !prev_ready)
        check("stable_during_stall", {bus.m_valid, bus.m_data, bus.m_last},
              {1'b1, prev_data, prev_last});
      since_start++;
      if (bus.m_valid) begin
        if (!first_seen) begin
          check("first_valid_latency_le3", since_start <= 3, 1'b1);
          first_seen = 1'b1;
        end
        if (bus.m_ready) begin
          check("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_data", bus.m_data, e[1]);
            check("beat_last", bus.m_last, e[0]);
          end
          beat_cnt++;
          if (bus.m_last) begin
            check("beat_count", beat_cnt, exp_n);
            check("queue_drained", exp_q.size(), 0);
            if (!ready_random) check("bubbles_at_full_rate", bubbles, 0);
            busy_model = 1'b0;
            done_next  = 1'b1;
          end
        end
      end else if (busy_model && first_seen) begin
        bubbles++;
      end
      if (start && !busy_model) begin
        if (q_rows != '0 && int'(q_rows) <= DEPTH) begin
          busy_model  = 1'b1;
          first_seen  = 1'b0;
          since_start = 0;
          beat_cnt    = 0;
          bubbles     = 0;
        end else begin
          done_next = 1'b1;
        end
      end
      done_model = done_next;
      prev_valid = bus.m_valid;
      prev_ready = bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input int q);
    @(posedge clk);
    #1;
    start  = 1'b1;
    q_rows = AW'(q);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_cnt != d0, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beat_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("reached_beat", beat_cnt >= target, 1'b1);
  endtask

  task automatic run_frame(input int q, input bit rnd);
    int d0;
    ready_random = rnd;
    push_expected(q);
    d0 = done_cnt;
    pulse_start(q);
    wait_done(d0, 8 * DW * q + 50);
  endtask

  task automatic load_alt_rows();
    for (int i = 0; i < DEPTH; i++) ram[i] = rand_row();
    ram[0] = '1;
    ram[1] = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) ram[i] = rand_row();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // q=2, row0 ones, row1 zeros, full rate
    load_alt_rows();
    run_frame(2, 1'b0);

    // same frame under random back-pressure
    run_frame(2, 1'b1);

    // q=1, alternating column pattern
    for (int c = 0; c < DW; c++) ram[0][c] = 1'(c % 2);
    run_frame(1, 1'b0);

    // out-of-range row counts: no beats, done next cycle, busy stays low
    ready_random = 1'b0;
    d0 = done_cnt;
    pulse_start(0);
    wait_done(d0, 10);
    d0 = done_cnt;
    pulse_start(DEPTH + 1);
    wait_done(d0, 10);

    // second start mid-frame must be ignored
    load_alt_rows();
    push_expected(2);
    d0 = done_cnt;
    pulse_start(2);
    wait_beats(100, 400);
    pulse_start(5);
    wait_done(d0, 4000);

    // reset in the middle of a frame, then a fresh frame
    push_expected(2);
    pulse_start(2);
    wait_beats(300, 1000);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(2, 1'b0);

    // random contents and row counts under random back-pressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = rand_row();
      run_frame($urandom_range(1, 6), 1'b1);
    end

    check("scoreboard_empty_at_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
